// File: rtl/heap_cmd_arbiter_if.sv
// Command bus between NUM_REQ requesters and the arbiter, plus the arbiter's
// control channel to the shared priority-heap engine.
interface heap_cmd_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int CAPACITY = 1024
);
  // Occupancy must represent 0..CAPACITY inclusive so that "full" is visible.
  localparam int N_W = $clog2(CAPACITY + 1);

  // Handshake: req[i] is a level held until ack[i]. ack is a one-cycle pulse,
  // and ack_err/rsp_data are valid only in that cycle. The requester drops
  // req[i] on the clock edge that ends the ack cycle. heap_start is a one-cycle
  // pulse; heap_instruction/heap_key stay stable until heap_done arrives.
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_key;
  logic [NUM_REQ-1:0]    ack;
  logic                  ack_err;
  logic [31:0]           rsp_data;
  logic [2:0]            grant_id;
  logic                  busy;
  logic                  timeout_flag;
  logic                  heap_start;
  logic [1:0]            heap_instruction;
  logic [31:0]           heap_key;
  logic                  heap_done;
  logic [N_W-1:0]        heap_n;
  logic [31:0]           heap_top;
  logic [1:0]            state_dbg;

  modport master (
    output req, req_op, req_key, heap_done, heap_n, heap_top,
    input  ack, ack_err, rsp_data, grant_id, busy, timeout_flag,
           heap_start, heap_instruction, heap_key, state_dbg
  );

  modport slave (
    input  req, req_op, req_key, heap_done, heap_n, heap_top,
    output ack, ack_err, rsp_data, grant_id, busy, timeout_flag,
           heap_start, heap_instruction, heap_key, state_dbg
  );
endinterface

// File: rtl/heap_cmd_arbiter.sv
// Round-robin arbiter sharing one priority-heap engine among NUM_REQ requesters;
// filters illegal commands and guards the heap with a watchdog.
module heap_cmd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CAPACITY = 1024,
  parameter int TIMEOUT  = 4096
) (
  input logic             clk,
  input logic             reset,
  heap_cmd_arbiter_if.slave bus
);
  localparam int N_W  = $clog2(CAPACITY + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t             state, state_n;
  logic [2:0]         rr;
  logic [2:0]         winner;
  logic               found;
  logic [1:0]         win_op;
  logic [31:0]        win_key;
  logic [1:0]         op_q;
  logic [31:0]        key_q;
  logic [31:0]        cap_data;
  logic [WD_W-1:0]    wdog;
  logic               cmd_err;
  logic               wd_expire;
  logic [NUM_REQ-1:0] gnt_onehot;

  // First set request at or above rr, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && bus.req[j] && (((int'(rr) + k) % NUM_REQ) == j)) begin
          found  = 1'b1;
          winner = 3'(j);
        end
      end
    end
  end

  always_comb begin
    win_op     = '0;
    win_key    = '0;
    gnt_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == 3'(j)) begin
        win_op  = bus.req_op[2*j +: 2];
        win_key = bus.req_key[32*j +: 32];
      end
      gnt_onehot[j] = (bus.grant_id == 3'(j));
    end
  end

  always_comb begin
    cmd_err = ((op_q != OP_PUSH) && (op_q != OP_POP)) ||
              ((op_q == OP_PUSH) && (bus.heap_n == N_W'(CAPACITY))) ||
              ((op_q == OP_POP) && (bus.heap_n == '0));
    wd_expire = (wdog == WD_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (found) state_n = CHECK;
      CHECK: state_n = cmd_err ? RESP : WAIT;
      WAIT:  if (bus.heap_done || wd_expire) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ack              <= '0;
      bus.ack_err          <= 1'b0;
      bus.rsp_data         <= '0;
      bus.grant_id         <= '0;
      bus.busy             <= 1'b0;
      bus.timeout_flag     <= 1'b0;
      bus.heap_start       <= 1'b0;
      bus.heap_instruction <= '0;
      bus.heap_key         <= '0;
      rr                   <= '0;
      op_q                 <= '0;
      key_q                <= '0;
      cap_data             <= '0;
      wdog                 <= '0;
    end else begin
      bus.heap_start <= 1'b0;
      bus.busy       <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (found) begin
            bus.grant_id <= winner;
            op_q         <= win_op;
            key_q        <= win_key;
          end
        end
        CHECK: begin
          if (cmd_err) begin
            bus.ack      <= gnt_onehot;
            bus.ack_err  <= 1'b1;
            bus.rsp_data <= '0;
          end else begin
            bus.heap_start       <= 1'b1;
            bus.heap_instruction <= op_q;
            bus.heap_key         <= key_q;
            cap_data             <= (op_q == OP_POP) ? bus.heap_top : 32'h0;
            wdog                 <= '0;
          end
        end
        WAIT: begin
          if (bus.heap_done) begin
            bus.ack      <= gnt_onehot;
            bus.ack_err  <= 1'b0;
            bus.rsp_data <= cap_data;
          end else if (wd_expire) begin
            bus.ack          <= gnt_onehot;
            bus.ack_err      <= 1'b1;
            bus.rsp_data     <= '0;
            bus.timeout_flag <= 1'b1;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        RESP: begin
          bus.ack      <= '0;
          bus.ack_err  <= 1'b0;
          bus.rsp_data <= '0;
          rr           <= (bus.grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : bus.grant_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state_dbg = state;

endmodule

// File: tb/tb_heap_cmd_arbiter.sv
// Bench for heap_cmd_arbiter: directed vector table, reset/round-robin sequences,
// and randomized batches scored against a queue-based priority-heap model.
module tb_heap_cmd_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int CAPACITY = 1024;
  localparam int TIMEOUT  = 16;
  localparam int N_W      = $clog2(CAPACITY + 1);

  logic clk = 1'b0;
  logic reset;

  heap_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .CAPACITY(CAPACITY)) bus ();

  heap_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CAPACITY(CAPACITY), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard entries: {requester id, ack_err, rsp_data}
  logic [35:0] exp_q[$];

  // ---------------- heap engine stand-in ----------------
  logic [31:0] env_heap[$];
  logic        heap_model_on;
  int          fixed_delay;
  int          start_cnt = 0;
  logic [1:0]  last_op;
  logic [31:0] last_key;
  logic        resp_done;
  logic        stray_done;

  assign bus.heap_done = resp_done | stray_done;

  function automatic logic [31:0] env_top();
    logic [31:0] m;
    m = '0;
    foreach (env_heap[i]) if (env_heap[i] > m) m = env_heap[i];
    return m;
  endfunction

  task automatic env_refresh();
    if (heap_model_on) begin
      bus.heap_n   = N_W'(env_heap.size());
      bus.heap_top = env_top();
    end
  endtask

  task automatic env_apply();
    int mi;
    if (last_op == 2'b01) env_heap.push_back(last_key);
    else if (last_op == 2'b10 && env_heap.size() > 0) begin
      mi = 0;
      foreach (env_heap[i]) if (env_heap[i] > env_heap[mi]) mi = i;
      env_heap.delete(mi);
    end
    env_refresh();
  endtask

  initial begin
    int d;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.heap_start === 1'b1) begin
        start_cnt++;
        last_op  = bus.heap_instruction;
        last_key = bus.heap_key;
        d = heap_model_on ? int'($urandom_range(1, 5)) : fixed_delay;
        if (d > 0) begin
          repeat (d) @(negedge clk);
          resp_done = 1'b1;
          if (heap_model_on) env_apply();
          @(negedge clk);
          resp_done = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model (sorted queue, max at front) ----------------
  logic [31:0] ref_q[$];
  int          rr_model;
  logic [1:0]  cmd_op[NUM_REQ];
  logic [31:0] cmd_key[NUM_REQ];

  task automatic predict_batch(input logic [NUM_REQ-1:0] mask);
    int last;
    last = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      int pos;
      logic err;
      logic [31:0] rsp;
      idx = (rr_model + k) % NUM_REQ;
      if (mask[idx]) begin
        err = 1'b1;
        rsp = '0;
        if (cmd_op[idx] == 2'b01 && ref_q.size() < CAPACITY) begin
          err = 1'b0;
          pos = 0;
          while (pos < ref_q.size() && ref_q[pos] >= cmd_key[idx]) pos++;
          ref_q.insert(pos, cmd_key[idx]);
        end else if (cmd_op[idx] == 2'b10 && ref_q.size() > 0) begin
          err = 1'b0;
          rsp = ref_q.pop_front();
        end
        exp_q.push_back({3'(idx), err, rsp});
        last = idx;
      end
    end
    rr_model = (last + 1) % NUM_REQ;
  endtask

  // ---------------- driver ----------------
  task automatic run_batch(input logic [NUM_REQ-1:0] mask, output int first_lat);
    int pending;
    int cyc;
    logic [NUM_REQ-1:0] live;
    logic [35:0] e;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_op[2*i +: 2]   = cmd_op[i];
      bus.req_key[32*i +: 32] = cmd_key[i];
    end
    bus.req   = mask;
    live      = mask;
    pending   = $countones(mask);
    cyc       = 0;
    first_lat = -1;
    while (pending > 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        int id;
        id = 0;
        for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i]) id = i;
        if (first_lat < 0) first_lat = cyc;
        check("ack_onehot", 64'($onehot(bus.ack)), 1);
        check("ack_to_pending", 64'(live[id]), 1);
        check("grant_id", 64'(bus.grant_id), 64'(id));
        check("busy_in_resp", 64'(bus.busy), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack %0b expected none", bus.ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_id", 64'(id), 64'(e[35:33]));
          check("ack_err", 64'(bus.ack_err), 64'(e[32]));
          check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
        end
        bus.req[id] = 1'b0;
        live[id]    = 1'b0;
        pending--;
      end
    end
    if (pending > 0) begin
      checks++;
      errors++;
      $display("FAIL batch_timeout: %0d acks pending after %0d cycles, need 0", pending, cyc);
      bus.req = '0;
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 64'(bus.ack), 0);
    check({tag, "_ack_err"}, 64'(bus.ack_err), 0);
    check({tag, "_rsp_data"}, 64'(bus.rsp_data), 0);
    check({tag, "_grant_id"}, 64'(bus.grant_id), 0);
    check({tag, "_busy"}, 64'(bus.busy), 0);
    check({tag, "_timeout_flag"}, 64'(bus.timeout_flag), 0);
    check({tag, "_heap_start"}, 64'(bus.heap_start), 0);
    check({tag, "_heap_instruction"}, 64'(bus.heap_instruction), 0);
    check({tag, "_heap_key"}, 64'(bus.heap_key), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    env_heap.delete();
    ref_q.delete();
    exp_q.delete();
    rr_model = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] key;
    int          n;
    logic [31:0] top;
    int          delay;   // 0 = heap never answers
    logic        err;
    logic [31:0] rsp;
    int          lat;     // negedges from req to ack
    int          starts;
    logic        tmo;
  } vec_t;

  vec_t vecs[11];

  // ---------------- global guard ----------------
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int s0;
    logic exp_tf;
    logic [NUM_REQ-1:0] mask;
    int r;

    vecs[0]  = '{0, 2'b01, 32'h55,       0,    32'h0,    4, 1'b0, 32'h0,    7,  1, 1'b0};
    vecs[1]  = '{2, 2'b10, 32'h0,        3,    32'h99,   2, 1'b0, 32'h99,   5,  1, 1'b0};
    vecs[2]  = '{1, 2'b10, 32'h0,        0,    32'h77,   1, 1'b1, 32'h0,    2,  0, 1'b0};
    vecs[3]  = '{3, 2'b01, 32'h12,       1024, 32'h33,   1, 1'b1, 32'h0,    2,  0, 1'b0};
    vecs[4]  = '{0, 2'b11, 32'h34,       5,    32'h44,   1, 1'b1, 32'h0,    2,  0, 1'b0};
    vecs[5]  = '{1, 2'b00, 32'h56,       5,    32'h44,   1, 1'b1, 32'h0,    2,  0, 1'b0};
    vecs[6]  = '{3, 2'b01, 32'hdeadbeef, 1023, 32'h10,   1, 1'b0, 32'h0,    4,  1, 1'b0};
    vecs[7]  = '{2, 2'b10, 32'h0,        1,    32'ha5a5, 3, 1'b0, 32'ha5a5, 6,  1, 1'b0};
    vecs[8]  = '{1, 2'b10, 32'h0,        1024, 32'h7,    1, 1'b0, 32'h7,    4,  1, 1'b0};
    vecs[9]  = '{0, 2'b01, 32'h66,       2,    32'h20,   0, 1'b1, 32'h0,    18, 1, 1'b1};
    vecs[10] = '{2, 2'b01, 32'h1,        0,    32'h0,    2, 1'b0, 32'h0,    5,  1, 1'b0};

    reset         = 1'b1;
    bus.req       = '0;
    bus.req_op    = '0;
    bus.req_key   = '0;
    stray_done    = 1'b0;
    fixed_delay   = 1;
    heap_model_on = 1'b1;
    rr_model      = 0;
    env_refresh();
    repeat (2) @(negedge clk);
    check_zero("reset");
    check("reset_state", 64'(bus.state_dbg), 0);
    reset = 1'b0;

    // round robin from a fresh pointer, then pointer back at 0
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_op[i]  = 2'b01;
      cmd_key[i] = $urandom;
    end
    predict_batch(4'b1111);
    run_batch(4'b1111, lat);
    cmd_op[3] = 2'b10;
    predict_batch(4'b1001);
    run_batch(4'b1001, lat);

    // directed vectors against a fixed heap view
    heap_model_on = 1'b0;
    exp_tf        = 1'b0;
    foreach (vecs[v]) begin
      bus.heap_n     = N_W'(vecs[v].n);
      bus.heap_top   = vecs[v].top;
      fixed_delay    = vecs[v].delay;
      cmd_op[vecs[v].id]  = vecs[v].op;
      cmd_key[vecs[v].id] = vecs[v].key;
      exp_q.push_back({3'(vecs[v].id), vecs[v].err, vecs[v].rsp});
      s0 = start_cnt;
      run_batch(NUM_REQ'(1) << vecs[v].id, lat);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
      check($sformatf("v%0d_heap_starts", v), 64'(start_cnt - s0), 64'(vecs[v].starts));
      if (vecs[v].starts == 1) begin
        check($sformatf("v%0d_heap_instruction", v), 64'(last_op), 64'(vecs[v].op));
        check($sformatf("v%0d_heap_key", v), 64'(last_key), 64'(vecs[v].key));
      end
      exp_tf = exp_tf | vecs[v].tmo;
      check($sformatf("v%0d_timeout_flag", v), 64'(bus.timeout_flag), 64'(exp_tf));
      @(negedge clk);
      check($sformatf("v%0d_ack_clear", v), 64'(bus.ack), 0);
      check($sformatf("v%0d_err_clear", v), 64'(bus.ack_err), 0);
      check($sformatf("v%0d_rsp_clear", v), 64'(bus.rsp_data), 0);
      check($sformatf("v%0d_idle_busy", v), 64'(bus.busy), 0);
    end

    // heap_done outside WAIT must not produce a response
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_done_ack", 64'(bus.ack), 0);
    check("stray_done_busy", 64'(bus.busy), 0);

    // reset while waiting on the heap
    fixed_delay      = 0;
    bus.heap_n       = N_W'(2);
    cmd_op[2]        = 2'b01;
    cmd_key[2]       = 32'h77;
    @(negedge clk);
    bus.req_op[5:4]   = cmd_op[2];
    bus.req_key[95:64] = cmd_key[2];
    bus.req          = 4'b0100;
    r = 0;
    while (bus.heap_start !== 1'b1 && r < 10) begin
      @(negedge clk);
      r++;
    end
    check("rst_wait_start_seen", 64'(bus.heap_start), 1);
    @(negedge clk);
    check("rst_wait_busy", 64'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    check_zero("async_reset");
    bus.req = '0;
    env_heap.delete();
    ref_q.delete();
    exp_q.delete();
    rr_model = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    heap_model_on = 1'b1;
    env_refresh();

    // after reset the pointer restarts at requester 0
    cmd_op[0]  = 2'b01;
    cmd_key[0] = 32'h1234;
    cmd_op[3]  = 2'b01;
    cmd_key[3] = 32'h4321;
    predict_batch(4'b1001);
    run_batch(4'b1001, lat);

    // randomized batches
    apply_reset();
    env_refresh();
    for (int b = 0; b < 30; b++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        r = $urandom_range(0, 9);
        if (r < 5)      cmd_op[i] = 2'b01;
        else if (r < 9) cmd_op[i] = 2'b10;
        else            cmd_op[i] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        cmd_key[i] = $urandom;
      end
      predict_batch(mask);
      run_batch(mask, lat);
    end
    check("random_timeout_flag", 64'(bus.timeout_flag), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
